simd_bram_loader: RTL and testbench

- Upstream feeder for the SIMD datapath top level.
- Takes a 32-bit AXI4-Stream from the PS DMA and packs consecutive words into full BRAM rows. PE_COUNT words make an A/B row; INS_WIDTH/DATA_WIDTH words make an instruction.
- Drives the A, B and INS BRAM write ports directly, one row per write pulse.
- A single command (target, base address, row count) is accepted while idle and is acknowledged with a done pulse.

---
 rtl/simd_pkg.sv | 24 ++
 rtl/simd_row_packer.sv | 50 +++++
 rtl/simd_bram_loader.sv | 174 +++++++++++++++++
 tb/tb_simd_bram_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types and helpers for the SIMD BRAM loader.
package simd_pkg;

  typedef enum logic [1:0] {
    TGT_A   = 2'd0,
    TGT_B   = 2'd1,
    TGT_INS = 2'd2,
    TGT_BAD = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_FIN
  } state_e;

  // Stream words needed to fill one row of the selected BRAM.
  function automatic int unsigned wpr_of(tgt_e tgt, int unsigned pe_count,
                                         int unsigned ins_words);
    return (tgt == TGT_INS) ? ins_words : pe_count;
  endfunction

endpackage

// File: rtl/simd_row_packer.sv
// Packs consecutive stream words into lanes of a row; lane 0 is the first word.
module simd_row_packer #(
  parameter int MAX_LANES  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 in_vld,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic [IDX_W-1:0]                     wpr_m1,
  output logic                                 row_full,
  output logic [MAX_LANES-1:0][DATA_WIDTH-1:0] row_data
);

  logic [MAX_LANES-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;

  // Merge the incoming word into its lane; the merged row is visible the same cycle.
  always_comb begin
    lanes_d  = lanes_q;
    idx_d    = idx_q;
    row_full = 1'b0;
    if (clr) begin
      idx_d = '0;
    end else if (in_vld) begin
      lanes_d[idx_q] = in_data;
      if (idx_q == wpr_m1) begin
        row_full = 1'b1;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    row_data = lanes_d;
  end

  // Lane storage and word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      idx_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/simd_bram_loader.sv
// AXI4-Stream to A/B/INS BRAM row loader with a single-command interface.
module simd_bram_loader
  import simd_pkg::*;
#(
  parameter int PE_COUNT       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int BRAM_DEPTH     = 1024,
  parameter int ADDR_WIDTH     = $clog2(BRAM_DEPTH),
  parameter int INS_ADDR_WIDTH = 11,
  parameter int INS_WIDTH      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_start,
  input  logic [1:0]                     cmd_target,
  input  logic [INS_ADDR_WIDTH-1:0]      cmd_base,
  input  logic [INS_ADDR_WIDTH:0]        cmd_rows,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic                           bram_a_wr_en,
  output logic [ADDR_WIDTH-1:0]          bram_a_wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0] bram_a_wr_data,
  output logic                           bram_b_wr_en,
  output logic [ADDR_WIDTH-1:0]          bram_b_wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0] bram_b_wr_data,
  output logic                           bram_ins_wr_en,
  output logic [INS_ADDR_WIDTH-1:0]      bram_ins_wr_addr,
  output logic [INS_WIDTH-1:0]           bram_ins_wr_data
);

  localparam int INS_WORDS = INS_WIDTH / DATA_WIDTH;
  localparam int MAX_LANES = (PE_COUNT > INS_WORDS) ? PE_COUNT : INS_WORDS;
  localparam int IDX_W     = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;
  localparam int IAW       = INS_ADDR_WIDTH;

  state_e                               state_q, state_d;
  tgt_e                                 tgt_q, tgt_d;
  logic [IAW-1:0]                       base_q, base_d, waddr_q, waddr_d;
  logic [IAW:0]                         rows_q, rows_d, row_cnt_q, row_cnt_d;
  logic                                 err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic                                 tready_q, tready_d;
  logic                                 wr_a_en_q, wr_a_en_d, wr_b_en_q, wr_b_en_d;
  logic                                 wr_ins_en_q, wr_ins_en_d;
  logic [MAX_LANES-1:0][DATA_WIDTH-1:0] row_data_q, row_data_d, pk_row;
  logic                                 hs, pk_full, last_word;
  logic [IDX_W-1:0]                     wpr_m1;

  // tready is only high in LOAD, so a handshake implies LOAD.
  assign hs        = s_axis_tvalid & tready_q;
  assign wpr_m1    = IDX_W'(wpr_of(tgt_q, PE_COUNT, INS_WORDS) - 1);
  assign last_word = pk_full && (row_cnt_q == rows_q - 1'b1);

  simd_row_packer #(
    .MAX_LANES (MAX_LANES),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_IDLE),
    .in_vld  (hs),
    .in_data (s_axis_tdata),
    .wpr_m1  (wpr_m1),
    .row_full(pk_full),
    .row_data(pk_row)
  );

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    base_d      = base_q;
    rows_d      = rows_q;
    row_cnt_d   = row_cnt_q;
    err_d       = err_q;
    waddr_d     = waddr_q;
    row_data_d  = row_data_q;
    wr_a_en_d   = 1'b0;
    wr_b_en_d   = 1'b0;
    wr_ins_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          tgt_d     = tgt_e'(cmd_target);
          base_d    = cmd_base;
          rows_d    = cmd_rows;
          row_cnt_d = '0;
          err_d     = (cmd_target == TGT_BAD);
          state_d   = (cmd_rows == '0 || cmd_target == TGT_BAD) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          if (pk_full) begin
            wr_a_en_d   = (tgt_q == TGT_A);
            wr_b_en_d   = (tgt_q == TGT_B);
            wr_ins_en_d = (tgt_q == TGT_INS);
            waddr_d     = base_q + row_cnt_q[IAW-1:0];
            row_data_d  = pk_row;
            row_cnt_d   = row_cnt_q + 1'b1;
          end
          if (last_word) begin
            state_d = ST_FLUSH;
            if (!s_axis_tlast) err_d = 1'b1;
          end else if (s_axis_tlast) begin
            // Early end of stream: the partial row stays in the packer and is dropped.
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_FLUSH: state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
    tready_d = (state_d == ST_LOAD);
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
    done_d   = (state_d == ST_FIN);
  end

  // FSM state, command context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tgt_q       <= TGT_A;
      base_q      <= '0;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tready_q    <= 1'b0;
      waddr_q     <= '0;
      row_data_q  <= '0;
      wr_a_en_q   <= 1'b0;
      wr_b_en_q   <= 1'b0;
      wr_ins_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      base_q      <= base_d;
      rows_q      <= rows_d;
      row_cnt_q   <= row_cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tready_q    <= tready_d;
      waddr_q     <= waddr_d;
      row_data_q  <= row_data_d;
      wr_a_en_q   <= wr_a_en_d;
      wr_b_en_q   <= wr_b_en_d;
      wr_ins_en_q <= wr_ins_en_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign s_axis_tready    = tready_q;
  assign bram_a_wr_en     = wr_a_en_q;
  assign bram_a_wr_addr   = waddr_q[ADDR_WIDTH-1:0];
  assign bram_a_wr_data   = row_data_q[PE_COUNT-1:0];
  assign bram_b_wr_en     = wr_b_en_q;
  assign bram_b_wr_addr   = waddr_q[ADDR_WIDTH-1:0];
  assign bram_b_wr_data   = row_data_q[PE_COUNT-1:0];
  assign bram_ins_wr_en   = wr_ins_en_q;
  assign bram_ins_wr_addr = waddr_q;
  assign bram_ins_wr_data = row_data_q[INS_WORDS-1:0];

endmodule

// File: tb/tb_simd_bram_loader.sv
// Scoreboard bench for simd_bram_loader: expected writes/dones queued by stimulus, checked by a monitor.
module tb_simd_bram_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_start;
  logic [1:0]   cmd_target;
  logic [10:0]  cmd_base;
  logic [11:0]  cmd_rows;
  logic         busy, done, err;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic         bram_a_wr_en, bram_b_wr_en, bram_ins_wr_en;
  logic [9:0]   bram_a_wr_addr, bram_b_wr_addr;
  logic [255:0] bram_a_wr_data, bram_b_wr_data;
  logic [10:0]  bram_ins_wr_addr;
  logic [63:0]  bram_ins_wr_data;

  simd_bram_loader dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_base(cmd_base), .cmd_rows(cmd_rows),
    .busy(busy), .done(done), .err(err),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .bram_a_wr_en(bram_a_wr_en), .bram_a_wr_addr(bram_a_wr_addr), .bram_a_wr_data(bram_a_wr_data),
    .bram_b_wr_en(bram_b_wr_en), .bram_b_wr_addr(bram_b_wr_addr), .bram_b_wr_data(bram_b_wr_data),
    .bram_ins_wr_en(bram_ins_wr_en), .bram_ins_wr_addr(bram_ins_wr_addr),
    .bram_ins_wr_data(bram_ins_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   tgt;
    logic [10:0]  addr;
    logic [255:0] data;
  } wr_t;

  typedef struct {
    logic err;
    bit   chk_lat;
  } dn_t;

  wr_t exp_wr[$];
  dn_t exp_dn[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  last_wr_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [255:0] act, logic [255:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected A/B row of eight consecutive words starting at w0.
  task automatic exp_row8(logic [1:0] tgt, logic [10:0] addr, logic [31:0] w0);
    wr_t e;
    e.tgt  = tgt;
    e.addr = addr;
    e.data = '0;
    for (int i = 0; i < 8; i++) e.data[i*32 +: 32] = w0 + 32'(i);
    exp_wr.push_back(e);
  endtask

  task automatic exp_ins(logic [10:0] addr, logic [63:0] data);
    wr_t e;
    e.tgt  = 2'd2;
    e.addr = addr;
    e.data = {192'b0, data};
    exp_wr.push_back(e);
  endtask

  task automatic exp_done(logic e_err, bit lat);
    dn_t d;
    d.err     = e_err;
    d.chk_lat = lat;
    exp_dn.push_back(d);
  endtask

  // Monitor: every strobe and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = int'(bram_a_wr_en) + int'(bram_b_wr_en) + int'(bram_ins_wr_en);
      if (n > 1) check("single_wr_en", 256'(n), 256'd1);
      if (n != 0) begin
        logic [1:0]   at;
        logic [10:0]  aa;
        logic [255:0] ad;
        at = bram_a_wr_en ? 2'd0 : (bram_b_wr_en ? 2'd1 : 2'd2);
        aa = bram_a_wr_en ? {1'b0, bram_a_wr_addr} :
             (bram_b_wr_en ? {1'b0, bram_b_wr_addr} : bram_ins_wr_addr);
        ad = bram_a_wr_en ? bram_a_wr_data :
             (bram_b_wr_en ? bram_b_wr_data : {192'b0, bram_ins_wr_data});
        last_wr_cyc = cyc;
        if (exp_wr.size() == 0) begin
          check("unexpected_wr", 256'(n), 256'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_target", 256'(at), 256'(e.tgt));
          check("wr_addr", 256'(aa), 256'(e.addr));
          check("wr_data", ad, e.data);
        end
      end
      if (done) begin
        if (exp_dn.size() == 0) begin
          check("unexpected_done", 256'(done), 256'd0);
        end else begin
          dn_t d;
          d = exp_dn.pop_front();
          check("done_err", 256'(err), 256'(d.err));
          check("done_busy_low", 256'(busy), 256'd0);
          if (d.chk_lat) check("done_latency", 256'(cyc - last_wr_cyc), 256'd1);
        end
      end
    end
  end

  task automatic cmd(logic [1:0] t, logic [10:0] b, logic [11:0] r);
    cmd_start  = 1'b1;
    cmd_target = t;
    cmd_base   = b;
    cmd_rows   = r;
    @(posedge clk); #1;
    cmd_start  = 1'b0;
  endtask

  // Present one word and hold it until the handshake edge.
  task automatic send(logic [31:0] w, logic last);
    int t;
    s_axis_tdata  = w;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      t++;
      if (t > 50) begin
        check("tready_timeout", 256'd0, 256'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_stream();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      t++;
      if (t > 100) begin
        check("done_timeout", 256'd0, 256'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int g;
    rst = 1'b1; cmd_start = 1'b0; cmd_target = '0; cmd_base = '0; cmd_rows = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 256'(|{busy, done, err, s_axis_tready, bram_a_wr_en, bram_b_wr_en,
          bram_ins_wr_en, bram_a_wr_addr, bram_a_wr_data, bram_ins_wr_addr, bram_ins_wr_data}), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // A load, base 5, two rows.
    exp_row8(2'd0, 11'd5, 32'h00);
    exp_row8(2'd0, 11'd6, 32'h08);
    exp_done(1'b0, 1'b1);
    cmd(2'd0, 11'd5, 12'd2);
    for (int i = 0; i < 16; i++) send(32'(i), i == 15);
    idle_stream();
    wait_done();

    // Stream is not accepted while idle.
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD;
    repeat (3) begin
      @(negedge clk);
      check("idle_tready", 256'(s_axis_tready), 256'd0);
    end
    @(posedge clk); #1;
    idle_stream();

    // INS load wrapping at the top of the instruction address space.
    exp_ins(11'h7FF, 64'h0000000B_0000000A);
    exp_ins(11'h000, 64'h0000000D_0000000C);
    exp_done(1'b0, 1'b1);
    cmd(2'd2, 11'h7FF, 12'd2);
    send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b0); send(32'hD, 1'b1);
    idle_stream();
    wait_done();

    // B load with early tlast on word 11: only row 0 lands.
    exp_row8(2'd1, 11'h20, 32'h40);
    exp_done(1'b1, 1'b0);
    cmd(2'd1, 11'h20, 12'd2);
    for (int i = 0; i < 11; i++) send(32'h40 + 32'(i), i == 10);
    idle_stream();
    wait_done();
    @(negedge clk);
    check("err_sticky", 256'(err), 256'd1);
    @(posedge clk); #1;

    // rows=0: immediate done, and the new start clears err.
    exp_done(1'b0, 1'b0);
    cmd(2'd0, 11'd0, 12'd0);
    wait_done();
    @(negedge clk);
    check("err_cleared", 256'(err), 256'd0);
    @(posedge clk); #1;

    // Illegal target.
    exp_done(1'b1, 1'b0);
    cmd(2'd3, 11'd0, 12'd4);
    wait_done();

    // A load with stream gaps, address wrap at 1024, and a stray start mid-load.
    exp_row8(2'd0, 11'h3FE, 32'h100);
    exp_row8(2'd0, 11'h3FF, 32'h108);
    exp_row8(2'd0, 11'h000, 32'h110);
    exp_done(1'b0, 1'b1);
    cmd(2'd0, 11'h3FE, 12'd3);
    for (int i = 0; i < 24; i++) begin
      send(32'h100 + 32'(i), i == 23);
      if (i < 23) begin
        g = (i == 4) ? 1 : int'($urandom_range(0, 2));
        if (g > 0) begin
          s_axis_tvalid = 1'b0;
          if (i == 4) begin
            cmd_start = 1'b1; cmd_target = 2'd3; cmd_rows = 12'd0;
          end
          repeat (g) begin
            @(posedge clk); #1;
            cmd_start = 1'b0;
          end
        end
      end
    end
    idle_stream();
    wait_done();

    // Missing tlast on the final word: row still written, err set.
    exp_ins(11'd3, 64'h00000022_00000011);
    exp_done(1'b1, 1'b1);
    cmd(2'd2, 11'd3, 12'd1);
    send(32'h11, 1'b0); send(32'h22, 1'b0);
    idle_stream();
    wait_done();

    // Reset after five words of an A load: nothing written, no done.
    cmd(2'd0, 11'd0, 12'd2);
    for (int i = 0; i < 5; i++) send(32'h80 + 32'(i), 1'b0);
    idle_stream();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midload_reset_outs", 256'(|{busy, done, err, s_axis_tready, bram_a_wr_en,
          bram_b_wr_en, bram_ins_wr_en, bram_a_wr_data, bram_ins_wr_data}), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Fresh load after reset.
    exp_row8(2'd0, 11'd1, 32'h50);
    exp_done(1'b0, 1'b1);
    cmd(2'd0, 11'd1, 12'd1);
    for (int i = 0; i < 8; i++) send(32'h50 + 32'(i), i == 7);
    idle_stream();
    wait_done();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wr_queue_drained", 256'(exp_wr.size()), 256'd0);
    check("done_queue_drained", 256'(exp_dn.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
